// File: rtl/dma_read_data_to_mem.sv
// Host-to-memory copy engine: issues one DMA read and one matching memory write command,
// streams the returned DMA data into the memory write channel, and retires the transfer on write status.
module dma_read_data_to_mem #(
  parameter int DATA_BYTES = 64
) (
  input  logic                    clk,
  input  logic                    rstn,
  output logic                    axis_dma_read_cmd_valid,
  input  logic                    axis_dma_read_cmd_ready,
  output logic [63:0]             axis_dma_read_cmd_address,
  output logic [31:0]             axis_dma_read_cmd_length,
  input  logic                    axis_dma_read_data_valid,
  output logic                    axis_dma_read_data_ready,
  input  logic [8*DATA_BYTES-1:0] axis_dma_read_data_data,
  input  logic [DATA_BYTES-1:0]   axis_dma_read_data_keep,
  input  logic                    axis_dma_read_data_last,
  output logic                    m_axis_mem_write_cmd_valid,
  input  logic                    m_axis_mem_write_cmd_ready,
  output logic [63:0]             m_axis_mem_write_cmd_address,
  output logic [31:0]             m_axis_mem_write_cmd_length,
  input  logic                    s_axis_mem_write_sts_valid,
  output logic                    s_axis_mem_write_sts_ready,
  input  logic [7:0]              s_axis_mem_write_sts_data,
  output logic                    m_axis_mem_write_data_valid,
  input  logic                    m_axis_mem_write_data_ready,
  output logic [8*DATA_BYTES-1:0] m_axis_mem_write_data_data,
  output logic [DATA_BYTES-1:0]   m_axis_mem_write_data_keep,
  output logic                    m_axis_mem_write_data_last,
  input  logic                    s_axis_put_data_cmd_valid,
  output logic                    s_axis_put_data_cmd_ready,
  input  logic [95:0]             s_axis_put_data_cmd_data,
  input  logic [15:0][31:0]       control_reg,
  output logic [1:0][31:0]        status_reg
);
  localparam int OFF_W  = $clog2(DATA_BYTES);
  localparam int BEAT_W = 33 - OFF_W;

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_STS} state_t;

  state_t            r_state, w_state_next;
  logic              r_run;
  logic [31:0]       r_len;
  logic [63:0]       r_host_addr, r_mem_addr;
  logic              r_dma_cmd_done, r_mem_cmd_done;
  logic [BEAT_W-1:0] r_beats_left;
  logic [31:0]       r_done_cnt, r_err_cnt;

  logic [31:0]           w_len;
  logic [BEAT_W-1:0]     w_beats;
  logic                  w_put_hs, w_dma_cmd_hs, w_mem_cmd_hs, w_data_hs, w_sts_hs;
  logic                  w_in_data, w_last;
  logic [OFF_W-1:0]      w_tail;
  logic [DATA_BYTES-1:0] w_tail_keep;
  logic                  w_unused;

  assign w_len   = s_axis_put_data_cmd_data[31:0];
  // Beat count is ceil(L/DATA_BYTES), formed without a 32-bit add that could overflow.
  assign w_beats = BEAT_W'(w_len >> OFF_W) + BEAT_W'(|w_len[OFF_W-1:0]);

  assign s_axis_put_data_cmd_ready  = r_run && (r_state == S_IDLE);
  assign axis_dma_read_cmd_valid    = (r_state == S_CMD) && !r_dma_cmd_done;
  assign m_axis_mem_write_cmd_valid = (r_state == S_CMD) && !r_mem_cmd_done;
  assign axis_dma_read_cmd_address    = r_host_addr;
  assign axis_dma_read_cmd_length     = r_len;
  assign m_axis_mem_write_cmd_address = r_mem_addr;
  assign m_axis_mem_write_cmd_length  = r_len;

  assign w_in_data                   = (r_state == S_DATA);
  assign m_axis_mem_write_data_valid = w_in_data && axis_dma_read_data_valid;
  assign axis_dma_read_data_ready    = w_in_data && m_axis_mem_write_data_ready;
  assign m_axis_mem_write_data_data  = axis_dma_read_data_data;
  assign w_last                      = (r_beats_left == BEAT_W'(1));
  assign m_axis_mem_write_data_last  = w_in_data && w_last;
  assign m_axis_mem_write_data_keep  = w_last ? w_tail_keep : axis_dma_read_data_keep;

  assign s_axis_mem_write_sts_ready = (r_state == S_STS);

  assign w_put_hs     = s_axis_put_data_cmd_valid && s_axis_put_data_cmd_ready;
  assign w_dma_cmd_hs = axis_dma_read_cmd_valid && axis_dma_read_cmd_ready;
  assign w_mem_cmd_hs = m_axis_mem_write_cmd_valid && m_axis_mem_write_cmd_ready;
  assign w_data_hs    = m_axis_mem_write_data_valid && m_axis_mem_write_data_ready;
  assign w_sts_hs     = s_axis_mem_write_sts_valid && s_axis_mem_write_sts_ready;

  assign status_reg[0] = r_done_cnt;
  assign status_reg[1] = r_err_cnt;

  assign w_unused = &{1'b0, axis_dma_read_data_last, control_reg[15:3]};

  assign w_tail = r_len[OFF_W-1:0];

  always_comb begin
    w_tail_keep = '0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      w_tail_keep[i] = (w_tail == '0) || (OFF_W'(i) < w_tail);
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_put_hs && (w_len != 32'd0)) w_state_next = S_CMD;
      S_CMD:  if ((r_dma_cmd_done || w_dma_cmd_hs) && (r_mem_cmd_done || w_mem_cmd_hs))
                w_state_next = S_DATA;
      S_DATA: if (w_data_hs && w_last) w_state_next = S_STS;
      S_STS:  if (w_sts_hs) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state        <= S_IDLE;
      r_run          <= 1'b0;
      r_len          <= '0;
      r_host_addr    <= '0;
      r_mem_addr     <= '0;
      r_dma_cmd_done <= 1'b0;
      r_mem_cmd_done <= 1'b0;
      r_beats_left   <= '0;
      r_done_cnt     <= '0;
      r_err_cnt      <= '0;
    end else begin
      r_state <= w_state_next;
      r_run   <= 1'b1;
      if (w_put_hs) begin
        r_len          <= w_len;
        r_host_addr    <= {control_reg[1], control_reg[0]} + {32'd0, s_axis_put_data_cmd_data[63:32]};
        r_mem_addr     <= {32'd0, control_reg[2]} + {32'd0, s_axis_put_data_cmd_data[95:64]};
        r_beats_left   <= w_beats;
        r_dma_cmd_done <= 1'b0;
        r_mem_cmd_done <= 1'b0;
      end
      if (w_dma_cmd_hs) r_dma_cmd_done <= 1'b1;
      if (w_mem_cmd_hs) r_mem_cmd_done <= 1'b1;
      if (w_data_hs) r_beats_left <= r_beats_left - BEAT_W'(1);
      if (w_sts_hs) begin
        r_done_cnt <= r_done_cnt + 32'd1;
        if (s_axis_mem_write_sts_data != 8'd0) r_err_cnt <= r_err_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_dma_read_data_to_mem.sv
// Randomized bench for dma_read_data_to_mem: each scenario task checks the DUT against
// expectations derived from transfer length, offsets and base addresses.
module tb_dma_read_data_to_mem;
  localparam int DB = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rstn;
  logic              axis_dma_read_cmd_valid, axis_dma_read_cmd_ready;
  logic [63:0]       axis_dma_read_cmd_address;
  logic [31:0]       axis_dma_read_cmd_length;
  logic              axis_dma_read_data_valid, axis_dma_read_data_ready;
  logic [8*DB-1:0]   axis_dma_read_data_data;
  logic [DB-1:0]     axis_dma_read_data_keep;
  logic              axis_dma_read_data_last;
  logic              m_axis_mem_write_cmd_valid, m_axis_mem_write_cmd_ready;
  logic [63:0]       m_axis_mem_write_cmd_address;
  logic [31:0]       m_axis_mem_write_cmd_length;
  logic              s_axis_mem_write_sts_valid, s_axis_mem_write_sts_ready;
  logic [7:0]        s_axis_mem_write_sts_data;
  logic              m_axis_mem_write_data_valid, m_axis_mem_write_data_ready;
  logic [8*DB-1:0]   m_axis_mem_write_data_data;
  logic [DB-1:0]     m_axis_mem_write_data_keep;
  logic              m_axis_mem_write_data_last;
  logic              s_axis_put_data_cmd_valid, s_axis_put_data_cmd_ready;
  logic [95:0]       s_axis_put_data_cmd_data;
  logic [15:0][31:0] control_reg;
  logic [1:0][31:0]  status_reg;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_done = '0;
  logic [31:0] exp_err  = '0;

  dma_read_data_to_mem #(.DATA_BYTES(DB)) dut (
    .clk(clk), .rstn(rstn),
    .axis_dma_read_cmd_valid(axis_dma_read_cmd_valid),
    .axis_dma_read_cmd_ready(axis_dma_read_cmd_ready),
    .axis_dma_read_cmd_address(axis_dma_read_cmd_address),
    .axis_dma_read_cmd_length(axis_dma_read_cmd_length),
    .axis_dma_read_data_valid(axis_dma_read_data_valid),
    .axis_dma_read_data_ready(axis_dma_read_data_ready),
    .axis_dma_read_data_data(axis_dma_read_data_data),
    .axis_dma_read_data_keep(axis_dma_read_data_keep),
    .axis_dma_read_data_last(axis_dma_read_data_last),
    .m_axis_mem_write_cmd_valid(m_axis_mem_write_cmd_valid),
    .m_axis_mem_write_cmd_ready(m_axis_mem_write_cmd_ready),
    .m_axis_mem_write_cmd_address(m_axis_mem_write_cmd_address),
    .m_axis_mem_write_cmd_length(m_axis_mem_write_cmd_length),
    .s_axis_mem_write_sts_valid(s_axis_mem_write_sts_valid),
    .s_axis_mem_write_sts_ready(s_axis_mem_write_sts_ready),
    .s_axis_mem_write_sts_data(s_axis_mem_write_sts_data),
    .m_axis_mem_write_data_valid(m_axis_mem_write_data_valid),
    .m_axis_mem_write_data_ready(m_axis_mem_write_data_ready),
    .m_axis_mem_write_data_data(m_axis_mem_write_data_data),
    .m_axis_mem_write_data_keep(m_axis_mem_write_data_keep),
    .m_axis_mem_write_data_last(m_axis_mem_write_data_last),
    .s_axis_put_data_cmd_valid(s_axis_put_data_cmd_valid),
    .s_axis_put_data_cmd_ready(s_axis_put_data_cmd_ready),
    .s_axis_put_data_cmd_data(s_axis_put_data_cmd_data),
    .control_reg(control_reg),
    .status_reg(status_reg)
  );

  task automatic idle_inputs();
    axis_dma_read_cmd_ready     = 1'b0;
    axis_dma_read_data_valid    = 1'b0;
    axis_dma_read_data_data     = '0;
    axis_dma_read_data_keep     = '0;
    axis_dma_read_data_last     = 1'b0;
    m_axis_mem_write_cmd_ready  = 1'b0;
    s_axis_mem_write_sts_valid  = 1'b0;
    s_axis_mem_write_sts_data   = '0;
    m_axis_mem_write_data_ready = 1'b0;
    s_axis_put_data_cmd_valid   = 1'b0;
    s_axis_put_data_cmd_data    = '0;
  endtask

  // One full transfer: command, command handshakes (with optional ready delays),
  // data stream (optionally randomized on both sides), then write status.
  task automatic do_transfer(input logic [31:0] len, input logic [31:0] hoff, input logic [31:0] moff,
                             input int dma_dly, input int mem_dly, input bit rnd,
                             input logic [7:0] sts, input string tag);
    logic [63:0]     exp_host, exp_mem;
    logic [DB-1:0]   exp_tail_keep;
    logic [8*DB-1:0] beat_data[$];
    logic [DB-1:0]   beat_keep[$];
    logic [8*DB-1:0] d;
    longint unsigned n_beats;
    bit dma_seen, mem_seen, dma_hs, mem_hs, hs, pending;
    int idx;

    exp_host = {control_reg[1], control_reg[0]} + {32'd0, hoff};
    exp_mem  = {32'd0, control_reg[2]} + {32'd0, moff};
    n_beats  = (64'(len) + 64'd63) / 64'd64;
    exp_tail_keep = (len % 64 == 0) ? {DB{1'b1}} : ((64'd1 << (len % 64)) - 64'd1);
    for (longint unsigned b = 0; b < n_beats; b++) begin
      for (int w = 0; w < 16; w++) d[w*32 +: 32] = rnd ? $urandom() : 32'd0;
      beat_data.push_back(rnd ? d : 512'd1234);
      beat_keep.push_back(rnd ? {$urandom(), $urandom()} : {DB{1'b1}});
    end

    @(negedge clk);
    s_axis_put_data_cmd_valid = 1'b1;
    s_axis_put_data_cmd_data  = {moff, hoff, len};
    #1;
    checks++;
    if (s_axis_put_data_cmd_ready !== 1'b1) begin
      errors++; $display("FAIL %s put_ready got=%b exp=1", tag, s_axis_put_data_cmd_ready);
    end
    @(posedge clk);
    @(negedge clk);
    s_axis_put_data_cmd_valid   = 1'b0;
    axis_dma_read_data_valid    = 1'b1;
    axis_dma_read_data_data     = beat_data[0];
    axis_dma_read_data_keep     = beat_keep[0];
    m_axis_mem_write_data_ready = 1'b1;
    dma_seen = 1'b0;
    mem_seen = 1'b0;
    for (int cyc = 0; cyc < 200 && !(dma_seen && mem_seen); cyc++) begin
      if (cyc > 0) @(negedge clk);
      axis_dma_read_cmd_ready    = (cyc >= dma_dly);
      m_axis_mem_write_cmd_ready = (cyc >= mem_dly);
      #1;
      checks++;
      if (axis_dma_read_cmd_valid !== !dma_seen) begin
        errors++; $display("FAIL %s dma_cmd_valid cyc=%0d got=%b exp=%b", tag, cyc, axis_dma_read_cmd_valid, !dma_seen);
      end
      checks++;
      if (m_axis_mem_write_cmd_valid !== !mem_seen) begin
        errors++; $display("FAIL %s mem_cmd_valid cyc=%0d got=%b exp=%b", tag, cyc, m_axis_mem_write_cmd_valid, !mem_seen);
      end
      checks++;
      if (m_axis_mem_write_data_valid !== 1'b0 || axis_dma_read_data_ready !== 1'b0) begin
        errors++; $display("FAIL %s data_before_cmds got valid=%b ready=%b exp=0/0", tag,
                           m_axis_mem_write_data_valid, axis_dma_read_data_ready);
      end
      if (cyc == 0) begin
        checks++;
        if (axis_dma_read_cmd_address !== exp_host || axis_dma_read_cmd_length !== len) begin
          errors++; $display("FAIL %s dma_cmd got addr=%h len=%h exp addr=%h len=%h", tag,
                             axis_dma_read_cmd_address, axis_dma_read_cmd_length, exp_host, len);
        end
        checks++;
        if (m_axis_mem_write_cmd_address !== exp_mem || m_axis_mem_write_cmd_length !== len) begin
          errors++; $display("FAIL %s mem_cmd got addr=%h len=%h exp addr=%h len=%h", tag,
                             m_axis_mem_write_cmd_address, m_axis_mem_write_cmd_length, exp_mem, len);
        end
      end
      dma_hs = axis_dma_read_cmd_valid && axis_dma_read_cmd_ready;
      mem_hs = m_axis_mem_write_cmd_valid && m_axis_mem_write_cmd_ready;
      @(posedge clk);
      if (dma_hs) dma_seen = 1'b1;
      if (mem_hs) mem_seen = 1'b1;
    end
    checks++;
    if (!(dma_seen && mem_seen)) begin
      errors++; $display("FAIL %s cmd_timeout got dma=%b mem=%b exp=1/1", tag, dma_seen, mem_seen);
    end

    idx = 0;
    pending = 1'b0;
    for (int cyc = 0; cyc < 20000 && idx < n_beats; cyc++) begin
      @(negedge clk);
      axis_dma_read_cmd_ready    = 1'b0;
      m_axis_mem_write_cmd_ready = 1'b0;
      if (!pending) pending = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      axis_dma_read_data_valid    = pending;
      axis_dma_read_data_data     = beat_data[idx];
      axis_dma_read_data_keep     = beat_keep[idx];
      m_axis_mem_write_data_ready = rnd ? $urandom_range(0, 1) : 1'b1;
      #1;
      checks++;
      if (m_axis_mem_write_data_valid !== axis_dma_read_data_valid ||
          axis_dma_read_data_ready !== m_axis_mem_write_data_ready) begin
        errors++; $display("FAIL %s passthrough beat=%0d got valid=%b ready=%b exp valid=%b ready=%b", tag, idx,
                           m_axis_mem_write_data_valid, axis_dma_read_data_ready,
                           axis_dma_read_data_valid, m_axis_mem_write_data_ready);
      end
      hs = axis_dma_read_data_valid && m_axis_mem_write_data_ready;
      if (hs) begin
        checks++;
        if (m_axis_mem_write_data_data !== beat_data[idx]) begin
          errors++; $display("FAIL %s data beat=%0d got=%h exp=%h", tag, idx,
                             m_axis_mem_write_data_data[63:0], beat_data[idx][63:0]);
        end
        checks++;
        if (m_axis_mem_write_data_keep !== ((idx == n_beats - 1) ? exp_tail_keep : beat_keep[idx])) begin
          errors++; $display("FAIL %s keep beat=%0d got=%h exp=%h", tag, idx, m_axis_mem_write_data_keep,
                             (idx == n_beats - 1) ? exp_tail_keep : beat_keep[idx]);
        end
        checks++;
        if (m_axis_mem_write_data_last !== (idx == n_beats - 1)) begin
          errors++; $display("FAIL %s last beat=%0d got=%b exp=%b", tag, idx, m_axis_mem_write_data_last,
                             (idx == n_beats - 1));
        end
      end
      @(posedge clk);
      if (hs) begin
        idx++;
        pending = 1'b0;
      end
    end
    checks++;
    if (idx != n_beats) begin
      errors++; $display("FAIL %s data_timeout got beats=%0d exp=%0d", tag, idx, n_beats);
    end

    // An extra offered beat must not be forwarded once the stream is complete.
    @(negedge clk);
    axis_dma_read_data_valid    = 1'b1;
    m_axis_mem_write_data_ready = 1'b1;
    s_axis_mem_write_sts_valid  = 1'b0;
    #1;
    checks++;
    if (m_axis_mem_write_data_valid !== 1'b0 || axis_dma_read_data_ready !== 1'b0 ||
        s_axis_mem_write_sts_ready !== 1'b1) begin
      errors++; $display("FAIL %s sts_state got valid=%b ready=%b sts_ready=%b exp=0/0/1", tag,
                         m_axis_mem_write_data_valid, axis_dma_read_data_ready, s_axis_mem_write_sts_ready);
    end
    @(negedge clk);
    s_axis_mem_write_sts_valid = 1'b1;
    s_axis_mem_write_sts_data  = sts;
    @(posedge clk);
    exp_done = exp_done + 32'd1;
    if (sts != 8'd0) exp_err = exp_err + 32'd1;
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (status_reg[0] !== exp_done || status_reg[1] !== exp_err) begin
      errors++; $display("FAIL %s status got=%0d/%0d exp=%0d/%0d", tag, status_reg[0], status_reg[1], exp_done, exp_err);
    end
    checks++;
    if (s_axis_put_data_cmd_ready !== 1'b1 || s_axis_mem_write_sts_ready !== 1'b0) begin
      errors++; $display("FAIL %s back_to_idle got put_ready=%b sts_ready=%b exp=1/0", tag,
                         s_axis_put_data_cmd_ready, s_axis_mem_write_sts_ready);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rstn = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (axis_dma_read_cmd_valid !== 1'b0 || m_axis_mem_write_cmd_valid !== 1'b0 ||
        m_axis_mem_write_data_valid !== 1'b0 || s_axis_put_data_cmd_ready !== 1'b0) begin
      errors++; $display("FAIL reset_handshakes got %b%b%b%b exp=0000", axis_dma_read_cmd_valid,
                         m_axis_mem_write_cmd_valid, m_axis_mem_write_data_valid, s_axis_put_data_cmd_ready);
    end
    checks++;
    if (status_reg !== 64'd0) begin
      errors++; $display("FAIL reset_status got=%h exp=0", status_reg);
    end
    rstn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (s_axis_put_data_cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release put_ready got=%b exp=1", s_axis_put_data_cmd_ready);
    end
  endtask

  task automatic test_basic();
    do_transfer(32'h4000, 32'h1234, 32'h5678, 0, 0, 1'b0, 8'd0, "basic");
  endtask

  task automatic test_len100();
    do_transfer(32'd100, 32'h40, 32'h80, 0, 0, 1'b1, 8'd0, "len100");
  endtask

  task automatic test_cmd_delay();
    do_transfer(32'd300, 32'h10, 32'h20, 5, 0, 1'b1, 8'd0, "dma_cmd_delay");
    do_transfer(32'd64, 32'h30, 32'h40, 0, 3, 1'b1, 8'd0, "mem_cmd_delay");
  endtask

  task automatic test_backpressure();
    do_transfer(32'h1000, 32'h0, 32'h0, 0, 0, 1'b1, 8'd0, "backpressure");
  endtask

  task automatic test_sts_error();
    do_transfer(32'd65, 32'h100, 32'h200, 0, 0, 1'b1, 8'd3, "sts_error");
  endtask

  task automatic test_zero_len();
    @(negedge clk);
    s_axis_put_data_cmd_valid = 1'b1;
    s_axis_put_data_cmd_data  = {32'h5, 32'h6, 32'd0};
    axis_dma_read_data_valid  = 1'b1;
    m_axis_mem_write_data_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_axis_put_data_cmd_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (axis_dma_read_cmd_valid !== 1'b0 || m_axis_mem_write_cmd_valid !== 1'b0 ||
          m_axis_mem_write_data_valid !== 1'b0 || s_axis_put_data_cmd_ready !== 1'b1) begin
        errors++; $display("FAIL zero_len cyc=%0d got %b%b%b%b exp=0001", c, axis_dma_read_cmd_valid,
                           m_axis_mem_write_cmd_valid, m_axis_mem_write_data_valid, s_axis_put_data_cmd_ready);
      end
      checks++;
      if (status_reg[0] !== exp_done || status_reg[1] !== exp_err) begin
        errors++; $display("FAIL zero_len status got=%0d/%0d exp=%0d/%0d", status_reg[0], status_reg[1], exp_done, exp_err);
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    logic [31:0] len;
    for (int t = 0; t < 6; t++) begin
      len = $urandom_range(1, 700);
      do_transfer(len, $urandom(), $urandom(), $urandom_range(0, 3), $urandom_range(0, 3), 1'b1,
                  ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'd0, "random");
    end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    s_axis_put_data_cmd_valid   = 1'b1;
    s_axis_put_data_cmd_data    = {32'd0, 32'd0, 32'd640};
    axis_dma_read_cmd_ready     = 1'b1;
    m_axis_mem_write_cmd_ready  = 1'b1;
    axis_dma_read_data_valid    = 1'b1;
    m_axis_mem_write_data_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_axis_put_data_cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (m_axis_mem_write_data_valid !== 1'b0 || axis_dma_read_data_ready !== 1'b0 ||
        axis_dma_read_cmd_valid !== 1'b0 || status_reg !== 64'd0) begin
      errors++; $display("FAIL midflight_reset got valid=%b ready=%b cmd=%b status=%h exp=0/0/0/0",
                         m_axis_mem_write_data_valid, axis_dma_read_data_ready, axis_dma_read_cmd_valid, status_reg);
    end
    idle_inputs();
    exp_done = '0;
    exp_err  = '0;
    rstn = 1'b1;
    @(posedge clk);
    do_transfer(32'd129, 32'h8, 32'h9, 0, 0, 1'b1, 8'd0, "after_reset");
  endtask

  initial begin
    control_reg    = '0;
    control_reg[0] = 32'h1234_0000;
    control_reg[1] = 32'h0001_5678;
    control_reg[2] = 32'h1000_0000;
    test_reset();
    test_basic();
    test_len100();
    test_cmd_delay();
    test_backpressure();
    test_sts_error();
    test_zero_len();
    test_random();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
